// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_ctrl
//  Description : Time-multiplexed scan controller for an 8-digit common-anode
//                seven-segment display. Walks one active-low anode per slot,
//                drives the hex glyph and decimal point, supports per-digit
//                enable, leading-zero blanking and frame-aligned value update.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl #(
  parameter int SCAN_DIV  = 100000,
  parameter int DIV_W     = 17,
  parameter int BLANK_CYC = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] DATA,
  input  logic [7:0]  DP,
  input  logic [7:0]  EN,
  input  logic        LZB,
  input  logic        LOAD,
  output logic        PEND,
  output logic        FRAME,
  output logic [7:0]  AN,
  output logic [7:0]  SEG
);

  localparam logic [DIV_W-1:0] c_div_max = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] c_blank   = DIV_W'(BLANK_CYC);

  // Scan position
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic             frame_q, frame_d;

  // Active (displayed) and pending (shadow) values
  logic [31:0] data_act_q, data_act_d;
  logic [7:0]  dp_act_q, dp_act_d;
  logic [7:0]  en_act_q, en_act_d;
  logic [31:0] data_pend_q, data_pend_d;
  logic [7:0]  dp_pend_q, dp_pend_d;
  logic [7:0]  en_pend_q, en_pend_d;
  logic        pend_q, pend_d;

  // Registered pin drivers
  logic [7:0] an_q, an_d;
  logic [7:0] seg_q, seg_d;

  logic       w_slot_end;
  logic       w_wrap;
  logic [3:0] w_nib;
  logic [6:0] w_glyph;
  logic       w_upper_nz;
  logic       w_lead_blank;
  logic       w_lit;

  // Slot divider and digit index; FRAME is timed to be high during the wrap cycle
  always_comb begin
    w_slot_end = (div_q == c_div_max);
    w_wrap     = w_slot_end && (idx_q == 3'd7);
    div_d      = w_slot_end ? '0 : div_q + DIV_W'(1);
    idx_d      = w_slot_end ? idx_q + 3'd1 : idx_q;
    frame_d    = (div_d == c_div_max) && (idx_d == 3'd7);
  end

  // Shadow register: apply pending at frame wrap first, then a LOAD becomes pending
  always_comb begin
    data_act_d  = data_act_q;
    dp_act_d    = dp_act_q;
    en_act_d    = en_act_q;
    data_pend_d = data_pend_q;
    dp_pend_d   = dp_pend_q;
    en_pend_d   = en_pend_q;
    pend_d      = pend_q;
    if (w_wrap && pend_q) begin
      data_act_d = data_pend_q;
      dp_act_d   = dp_pend_q;
      en_act_d   = en_pend_q;
      pend_d     = 1'b0;
    end
    if (LOAD) begin
      data_pend_d = DATA;
      dp_pend_d   = DP;
      en_pend_d   = EN;
      pend_d      = 1'b1;
    end
  end

  // Leading-zero detection: any non-zero nibble or lit dp at or above the current digit
  always_comb begin
    w_upper_nz = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if ((3'(j) >= idx_q) && ((data_act_q[4*j +: 4] != 4'h0) || dp_act_q[j])) begin
        w_upper_nz = 1'b1;
      end
    end
    w_lead_blank = LZB && (idx_q != 3'd0) && !w_upper_nz;
  end

  // Hex glyph lookup for the current digit, active-low {g,f,e,d,c,b,a}
  always_comb begin
    w_nib = data_act_q[{idx_q, 2'b00} +: 4];
    case (w_nib)
      4'h0: w_glyph = 7'h40;
      4'h1: w_glyph = 7'h79;
      4'h2: w_glyph = 7'h24;
      4'h3: w_glyph = 7'h30;
      4'h4: w_glyph = 7'h19;
      4'h5: w_glyph = 7'h12;
      4'h6: w_glyph = 7'h02;
      4'h7: w_glyph = 7'h78;
      4'h8: w_glyph = 7'h00;
      4'h9: w_glyph = 7'h10;
      4'hA: w_glyph = 7'h08;
      4'hB: w_glyph = 7'h03;
      4'hC: w_glyph = 7'h46;
      4'hD: w_glyph = 7'h21;
      4'hE: w_glyph = 7'h06;
      default: w_glyph = 7'h0E;
    endcase
  end

  // Pin values for the current slot; guard cycles and unlit digits drive all-off
  always_comb begin
    w_lit = (div_q >= c_blank) && en_act_q[idx_q] && !w_lead_blank;
    an_d  = 8'hFF;
    seg_d = 8'hFF;
    if (w_lit) begin
      an_d  = ~(8'h01 << idx_q);
      seg_d = {~dp_act_q[idx_q], w_glyph};
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q       <= '0;
      idx_q       <= 3'd0;
      frame_q     <= 1'b0;
      data_act_q  <= 32'h0;
      dp_act_q    <= 8'h0;
      en_act_q    <= 8'h0;
      data_pend_q <= 32'h0;
      dp_pend_q   <= 8'h0;
      en_pend_q   <= 8'h0;
      pend_q      <= 1'b0;
      an_q        <= 8'hFF;
      seg_q       <= 8'hFF;
    end else begin
      div_q       <= div_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      data_act_q  <= data_act_d;
      dp_act_q    <= dp_act_d;
      en_act_q    <= en_act_d;
      data_pend_q <= data_pend_d;
      dp_pend_q   <= dp_pend_d;
      en_pend_q   <= en_pend_d;
      pend_q      <= pend_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign PEND  = pend_q;
  assign FRAME = frame_q;
  assign AN    = an_q;
  assign SEG   = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_ctrl
//  Description : Self-checking bench for seg7_scan_ctrl with a cycle-level
//                reference model driven by directed and random stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

  localparam int S  = 4;
  localparam int DW = 3;
  localparam int BC = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = 32'h0;
  logic [7:0]  dp = 8'h0;
  logic [7:0]  en = 8'h0;
  logic        lzb = 1'b0;
  logic        load = 1'b0;
  logic        pend;
  logic        frame;
  logic [7:0]  an;
  logic [7:0]  seg;

  seg7_scan_ctrl #(.SCAN_DIV(S), .DIV_W(DW), .BLANK_CYC(BC)) dut (
    .CLK(clk), .RST(rst), .DATA(data), .DP(dp), .EN(en), .LZB(lzb),
    .LOAD(load), .PEND(pend), .FRAME(frame), .AN(an), .SEG(seg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state
  int          m_cyc = 0;
  logic [31:0] m_adata = 0, m_pdata = 0;
  logic [7:0]  m_adp = 0, m_aen = 0, m_pdp = 0, m_pen = 0;
  bit          m_pend = 0;
  logic [7:0]  exp_an = 8'hFF, exp_seg = 8'hFF;
  bit          exp_frame = 0, exp_pend = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock: model predicts post-edge outputs from pre-edge state, then compare
  task automatic tick();
    int div, idx;
    bit lit;
    logic [3:0] nib;
    if (rst) begin
      m_cyc = 0; m_adata = 0; m_pdata = 0; m_adp = 0; m_aen = 0;
      m_pdp = 0; m_pen = 0; m_pend = 0;
      exp_an = 8'hFF; exp_seg = 8'hFF; exp_frame = 0; exp_pend = 0;
    end else begin
      div = m_cyc % S;
      idx = (m_cyc / S) % 8;
      nib = m_adata[4*idx +: 4];
      lit = (div >= BC) && m_aen[idx] &&
            !(idx > 0 && lzb && ((m_adata >> (4*idx)) == 0) && ((m_adp >> idx) == 0));
      if (lit) begin
        exp_an  = ~(8'h01 << idx);
        exp_seg = {~m_adp[idx], glyph_tab[nib]};
      end else begin
        exp_an  = 8'hFF;
        exp_seg = 8'hFF;
      end
      if (div == S-1 && idx == 7 && m_pend) begin
        m_adata = m_pdata; m_adp = m_pdp; m_aen = m_pen; m_pend = 0;
      end
      if (load) begin
        m_pdata = data; m_pdp = dp; m_pen = en; m_pend = 1;
      end
      m_cyc     = (m_cyc + 1) % (8*S);
      exp_frame = ((m_cyc % S) == S-1) && (((m_cyc / S) % 8) == 7);
      exp_pend  = m_pend;
    end
    @(posedge clk);
    #1;
    check("AN", an, exp_an);
    check("SEG", seg, exp_seg);
    check("PEND", pend, exp_pend);
    check("FRAME", frame, exp_frame);
    check("AN_onehot", ($countones(~an) <= 1), 1);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] e);
    data = d; dp = p; en = e; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Run until the model says FRAME is high in the current cycle, with a cycle budget
  task automatic wait_frame();
    int guard = 0;
    while (!exp_frame && guard < 10*8*S) begin
      tick();
      guard++;
    end
    check("wait_frame_timeout", exp_frame, 1);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    run(2);
    rst = 1'b0;

    // 1: basic ascending digits
    do_load(32'h76543210, 8'h00, 8'hFF);
    run(3*8*S);

    // 2: leading-zero blanking with a non-zero middle digit
    lzb = 1'b1;
    do_load(32'h000000A0, 8'h00, 8'hFF);
    run(2*8*S);

    // 3: last load wins, then load coincident with FRAME
    lzb = 1'b0;
    do_load(32'h11111111, 8'h00, 8'hFF);
    run(3);
    do_load(32'h22222222, 8'h00, 8'hFF);
    run(2*8*S);
    wait_frame();
    do_load(32'h89ABCDEF, 8'h5A, 8'hFF);
    run(2*8*S);

    // 4: partial enable mask
    do_load(32'h12345678, 8'h00, 8'h05);
    run(2*8*S);

    // 5: reset mid-slot with display lit; stays blank until a new load
    do_load(32'hFEDCBA98, 8'hFF, 8'hFF);
    run(8*S + 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(2*8*S);

    // 6: only the top decimal point keeps upper zeros visible
    lzb = 1'b1;
    do_load(32'h00000000, 8'h80, 8'hFF);
    run(2*8*S);

    // Random traffic
    for (int k = 0; k < 1500; k++) begin
      data = $urandom;
      dp   = 8'($urandom);
      en   = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        data = data & 32'h0000_0FFF;
        dp   = dp & 8'h07;
      end
      if ($urandom_range(0, 31) == 0) lzb = ~lzb;
      load = ($urandom_range(0, 15) == 0);
      rst  = ($urandom_range(0, 299) == 0);
      tick();
    end
    load = 1'b0;
    rst  = 1'b0;
    run(8*S);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
